mips_regfile_mp: RTL and testbench

- Parametrised multi-port general register file for the pipelined MIPS core. Generalises the single-write, two-read GRF.
- Configurable data width, depth and read-port count; two write ports.
- Same-cycle write-to-read bypass.
- Per-register pending scoreboard for hazard detection.
- Sequenced post-reset clear of the array.
- Sits between decode (reads, reserves) and writeback (two retiring writes).

---
 rtl/mips_regfile_mp.sv | 230 +++++++++++++++++++++++
 tb/tb_mips_regfile_mp.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : mips_regfile_mp
// Purpose  : Multi-port general register file for the pipelined MIPS core.
//            It has two write ports (writeback) and NUM_RD combinational read
//            ports (decode). A same-cycle write is bypassed to the read ports.
//            A per-register pending scoreboard is set by decode reserves and
//            cleared by retiring writes. After reset, a sequencer clears the
//            array one entry per cycle before the file reports ready.
//
// Ports    : clk, reset      - clock, synchronous active-high reset
//            ready           - array cleared and usable
//            rd_addr         - NUM_RD read addresses, port k at [k*ADDR_W +: ADDR_W]
//            rd_data         - NUM_RD read data,      port k at [k*DATA_W +: DATA_W]
//            rd_pending      - pending bit of each addressed register
//            we0/wa0/wd0/pc0 - write port 0 (pc0 only feeds the trace)
//            we1/wa1/wd1/pc1 - write port 1 (wins over port 0 on same address)
//            rsv_en/rsv_addr - mark a register pending (newer producer)
//
// Options  : define REGFILE_TRACE_EN to print one line per accepted write.
//
// Revision : 1.0 - initial release
// ============================================================================
module mips_regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2   // 1..4
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     ready,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic [31:0]              pc0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic [31:0]              pc1,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [0:0] c_CLEAR = 1'b0;
  localparam logic [0:0] c_RUN   = 1'b1;

  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] c_ZERO_ADDR = '0;
  localparam logic [DEPTH-1:0]  c_ONE_HOT0  = DEPTH'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]        r_state;
  logic [0:0]        w_state_next;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic              w_run;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_pend;

  // Qualified write / reserve strobes. Everything to register 0 is dropped,
  // and nothing is accepted while the clear sequence owns the array.
  logic w_wr0;
  logic w_wr1;
  logic w_rsv;

  assign w_wr0 = w_run && we0    && (wa0      != c_ZERO_ADDR);
  assign w_wr1 = w_run && we1    && (wa1      != c_ZERO_ADDR);
  assign w_rsv = w_run && rsv_en && (rsv_addr != c_ZERO_ADDR);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_CLEAR;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state. CLEAR leaves on the edge that zeroes the last entry, so
  // clr_ptr stops at DEPTH-1 and never wraps.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_CLEAR: begin
        if (r_clr_ptr == c_LAST_ADDR) begin
          w_state_next = c_RUN;
        end
      end
      c_RUN: begin
        w_state_next = c_RUN;
      end
      default: begin
        w_state_next = c_CLEAR;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_run = 1'b0;
    ready = 1'b0;
    if (r_state == c_RUN) begin
      w_run = 1'b1;
      ready = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Clear pointer. Entry 0 is never stored because it always reads as zero,
  // so the sweep starts at 1.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clr_ptr <= ADDR_W'(1);
    end else if ((r_state == c_CLEAR) && (r_clr_ptr != c_LAST_ADDR)) begin
      r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Storage array. It has no reset because the clear sequence initialises it.
  // Port 1 is written last, so it wins when both ports hit the same entry.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == c_CLEAR) begin
        r_mem[r_clr_ptr] <= '0;
      end else begin
        if (w_wr0) begin
          r_mem[wa0] <= wd0;
        end
        if (w_wr1) begin
          r_mem[wa1] <= wd1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pending scoreboard. Retiring writes clear their bit first, and then a
  // same-cycle reserve sets it again, because the reserve is the newer
  // producer. Bit 0 is forced low.
  // --------------------------------------------------------------------------
  logic [DEPTH-1:0] w_wr0_mask;
  logic [DEPTH-1:0] w_wr1_mask;
  logic [DEPTH-1:0] w_rsv_mask;
  logic [DEPTH-1:0] w_pend_next;

  always_comb begin
    w_wr0_mask  = w_wr0 ? (c_ONE_HOT0 << wa0)      : '0;
    w_wr1_mask  = w_wr1 ? (c_ONE_HOT0 << wa1)      : '0;
    w_rsv_mask  = w_rsv ? (c_ONE_HOT0 << rsv_addr) : '0;
    w_pend_next = ((r_pend & ~w_wr0_mask & ~w_wr1_mask) | w_rsv_mask) & ~c_ONE_HOT0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_next;
    end
  end

  // --------------------------------------------------------------------------
  // Read ports. A write in flight to the addressed register is forwarded, with
  // port 1 taking priority. The pending bit is not bypassed: it shows the
  // registered scoreboard.
  // --------------------------------------------------------------------------
  genvar k;
  generate
    for (k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic [DATA_W-1:0] w_data;

      assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];

      always_comb begin
        w_data = '0;
        if (w_run && (w_addr != c_ZERO_ADDR)) begin
          if (w_wr1 && (wa1 == w_addr)) begin
            w_data = wd1;
          end else if (w_wr0 && (wa0 == w_addr)) begin
            w_data = wd0;
          end else begin
            w_data = r_mem[w_addr];
          end
        end
      end

      assign rd_data[k*DATA_W +: DATA_W] = w_data;
      assign rd_pending[k]               = w_run & r_pend[w_addr];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Write trace. When both ports hit the same register, only the winning
  // port 1 write is reported.
  // --------------------------------------------------------------------------
`ifdef REGFILE_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_wr0 && !(w_wr1 && (wa1 == wa0))) begin
        $display("%d@%h: $%d <= %h", $time, pc0, wa0, wd0);
      end
      if (w_wr1) begin
        $display("%d@%h: $%d <= %h", $time, pc1, wa1, wd1);
      end
    end
  end
`else
  // The PCs only feed the trace.
  logic w_unused_pc;
  assign w_unused_pc = ^{pc0, pc1};
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_regfile_mp
// Purpose  : Directed self-checking bench for mips_regfile_mp with default
//            parameters (32-bit data, 32 registers, 2 read ports).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;

  logic                     clk;
  logic                     reset;
  logic                     ready;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pending;
  logic                     we0, we1, rsv_en;
  logic [ADDR_W-1:0]        wa0, wa1, rsv_addr;
  logic [DATA_W-1:0]        wd0, wd1;
  logic [31:0]              pc0, pc1;

  int n_chk;
  int n_err;

  mips_regfile_mp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ready      (ready),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_pending (rd_pending),
    .we0        (we0),
    .wa0        (wa0),
    .wd0        (wd0),
    .pc0        (pc0),
    .we1        (we1),
    .wa1        (wa1),
    .wd1        (wd1),
    .pc1        (pc1),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs settle by then.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int k, input logic [ADDR_W-1:0] a);
    rd_addr[k*ADDR_W +: ADDR_W] = a;
    #1;
  endtask

  function automatic logic [31:0] rdd(input int k);
    return rd_data[k*DATA_W +: DATA_W];
  endfunction

  task automatic idle_inputs();
    we0 = 1'b0; wa0 = '0; wd0 = '0; pc0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0; pc1 = '0;
    rsv_en = 1'b0; rsv_addr = '0;
    #1;
  endtask

  // Counts cycles from here until ready rises. The count is bounded.
  task automatic count_to_ready(output int cnt);
    cnt = 0;
    while (!ready && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    int cnt;
    logic [31:0] acc;
    n_chk = 0;
    n_err = 0;
    rd_addr = '0;
    idle_inputs();
    reset = 1'b1;

    // ---------------- reset and clear latency ----------------
    tick();
    reset = 1'b0;
    #1;
    check("reset_ready", {31'd0, ready}, 32'd0);
    set_rd(0, 5'd3);
    check("clear_rd0", rdd(0), 32'd0);
    check("clear_pend", {30'd0, rd_pending}, 32'd0);
    count_to_ready(cnt);
    check("ready_latency", cnt, 32'd31);
    check("ready_high", {31'd0, ready}, 32'd1);

    acc = '0;
    for (int a = 0; a < 32; a++) begin
      set_rd(0, 5'(a));
      set_rd(1, 5'(31 - a));
      acc = acc | rdd(0) | rdd(1) | {30'd0, rd_pending};
    end
    check("post_clear_all_zero", acc, 32'd0);

    // ---------------- bypass port 0 ----------------
    set_rd(0, 5'd5);
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h1234_5678; pc0 = 32'h0040_0000;
    #1;
    check("bypass_p0", rdd(0), 32'h1234_5678);
    tick();
    idle_inputs();
    check("stored_p0", rdd(0), 32'h1234_5678);

    // ---------------- both ports, same register ----------------
    set_rd(1, 5'd7);
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hAAAA_0000;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h5555_FFFF;
    #1;
    check("bypass_p1_wins", rdd(1), 32'h5555_FFFF);
    tick();
    idle_inputs();
    check("stored_p1_wins", rdd(1), 32'h5555_FFFF);

    // ---------------- both ports, different registers ----------------
    set_rd(0, 5'd3);
    set_rd(1, 5'd4);
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h0000_0333;
    we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h0000_0444;
    #1;
    check("bypass_split0", rdd(0), 32'h0000_0333);
    check("bypass_split1", rdd(1), 32'h0000_0444);
    tick();
    idle_inputs();
    check("stored_split0", rdd(0), 32'h0000_0333);
    check("stored_split1", rdd(1), 32'h0000_0444);
    set_rd(1, 5'd5);
    check("reg5_kept", rdd(1), 32'h1234_5678);

    // ---------------- scoreboard ----------------
    set_rd(0, 5'd9);
    rsv_en = 1'b1; rsv_addr = 5'd9;
    #1;
    check("pend_no_bypass", {31'd0, rd_pending[0]}, 32'd0);
    tick();
    idle_inputs();
    check("pend_set", {31'd0, rd_pending[0]}, 32'd1);
    check("pend_other_port", {31'd0, rd_pending[1]}, 32'd0);

    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h0000_0009;
    rsv_en = 1'b1; rsv_addr = 5'd9;
    tick();
    idle_inputs();
    check("pend_rsv_beats_wr", {31'd0, rd_pending[0]}, 32'd1);
    check("reg9_value", rdd(0), 32'h0000_0009);

    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h9999_9999;
    #1;
    check("pend_still_set", {31'd0, rd_pending[0]}, 32'd1);
    tick();
    idle_inputs();
    check("pend_cleared", {31'd0, rd_pending[0]}, 32'd0);
    check("reg9_value2", rdd(0), 32'h9999_9999);

    // ---------------- register 0 ----------------
    set_rd(0, 5'd0);
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF;
    rsv_en = 1'b1; rsv_addr = 5'd0;
    #1;
    check("r0_bypass", rdd(0), 32'd0);
    tick();
    idle_inputs();
    check("r0_read", rdd(0), 32'd0);
    check("r0_pend", {31'd0, rd_pending[0]}, 32'd0);

    // ---------------- reset during CLEAR ----------------
    reset = 1'b1;
    tick();
    reset = 1'b0;
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF;
    we1 = 1'b1; wa1 = 5'd12; wd1 = 32'hCAFE_F00D;
    rsv_en = 1'b1; rsv_addr = 5'd12;
    set_rd(0, 5'd5);
    set_rd(1, 5'd12);
    for (int i = 0; i < 10; i++) tick();
    check("mid_clear_ready", {31'd0, ready}, 32'd0);
    check("mid_clear_rd", rdd(0) | rdd(1), 32'd0);
    check("mid_clear_pend", {30'd0, rd_pending}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    count_to_ready(cnt);
    check("restart_latency", cnt, 32'd31);
    idle_inputs();

    acc = '0;
    for (int a = 0; a < 32; a++) begin
      set_rd(0, 5'(a));
      set_rd(1, 5'(31 - a));
      acc = acc | rdd(0) | rdd(1) | {30'd0, rd_pending};
    end
    check("restart_all_zero", acc, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
